// File: rtl/simple_ctrl.sv
// rtl/simple_ctrl.sv - SIMPLE core control sequencer: fetch, decode and exec over a req/ack port
// Owns the PC, the instruction register and halt state; drives all datapath controls.
module simple_ctrl (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] pc,
  output logic        ifetch_req,
  input  logic        ifetch_ack,
  input  logic [15:0] instr_in,
  input  logic        in_valid,
  output logic        in_ack,
  output logic        alu_en,
  output logic        sft_en,
  output logic        immd_en,
  output logic        in_en,
  output logic        out_en,
  output logic [3:0]  op3,
  output logic [7:0]  immd,
  output logic [2:0]  AR_idx,
  output logic [2:0]  BR_idx,
  output logic [2:0]  wr_idx,
  output logic        rdAR_en,
  output logic        rdBR_en,
  output logic        wr_en,
  output logic        halted
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [15:0] ir_q;
  logic        req_q;

  logic [1:0]  cls;
  logic [2:0]  rs;
  logic [2:0]  rd;
  logic [3:0]  f;
  logic        is_reg;
  logic        is_alu;
  logic        is_cmp;
  logic        is_sft;
  logic        is_in;
  logic        is_out;
  logic        is_hlt;
  logic        is_li;
  logic        exec_now;
  logic        read_phase;
  logic        in_fire;

  assign cls    = ir_q[15:14];
  assign rs     = ir_q[13:11];
  assign rd     = ir_q[10:8];
  assign f      = ir_q[7:4];
  assign is_reg = (cls == 2'b11);
  assign is_alu = is_reg && (f <= 4'd6);
  assign is_cmp = is_reg && (f == 4'd5);
  assign is_sft = is_reg && (f[3:2] == 2'b10);
  assign is_in  = is_reg && (f == 4'd12);
  assign is_out = is_reg && (f == 4'd13);
  assign is_hlt = is_reg && (f == 4'd15);
  assign is_li  = (cls == 2'b10) && (rs == 3'b000);

  assign pc_d = pc_q + 16'd1;

  // The req flag is cleared by reset so the first request appears one cycle after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= 16'h0000;
      ir_q    <= 16'h0000;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (req_q && ifetch_ack) begin
            ir_q    <= instr_in;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end else begin
            req_q   <= 1'b1;
          end
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          if (is_hlt) begin
            state_q <= S_HALT;
          end else if (!is_in || in_valid) begin
            pc_q    <= pc_d;
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_HALT: state_q <= S_HALT;
      endcase
    end
  end

  // Execute-phase strobes are suppressed combinationally so a reset cycle never commits a write.
  assign exec_now   = (state_q == S_EXEC) && !reset;
  assign read_phase = (state_q == S_DECODE) || (state_q == S_EXEC);
  assign in_fire    = exec_now && is_in && in_valid;

  assign pc         = pc_q;
  assign ifetch_req = req_q;
  assign halted     = (state_q == S_HALT);

  assign op3     = is_reg ? f : 4'h0;
  assign immd    = ir_q[7:0];
  assign AR_idx  = rd;
  assign BR_idx  = (is_alu || is_out) ? rs : rd;
  assign wr_idx  = rd;

  assign rdAR_en = read_phase && is_alu;
  assign rdBR_en = read_phase && (is_alu || is_sft || is_out);

  assign alu_en  = exec_now && is_alu;
  assign sft_en  = exec_now && is_sft;
  assign immd_en = exec_now && is_li;
  assign in_en   = in_fire;
  assign out_en  = exec_now && is_out;
  assign in_ack  = in_fire;
  assign wr_en   = (exec_now && ((is_alu && !is_cmp) || is_sft || is_li)) || in_fire;

endmodule

// File: tb/tb_simple_ctrl.sv
// tb/tb_simple_ctrl.sv - randomized self-checking bench for simple_ctrl against an instruction-level model
module tb_simple_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        ifetch_req;
  logic        ifetch_ack;
  logic [15:0] instr_in;
  logic        in_valid;
  logic        in_ack;
  logic        alu_en, sft_en, immd_en, in_en, out_en;
  logic [3:0]  op3;
  logic [7:0]  immd;
  logic [2:0]  AR_idx, BR_idx, wr_idx;
  logic        rdAR_en, rdBR_en, wr_en;
  logic        halted;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  assign instr_in = mem[pc[7:0]];

  simple_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .ifetch_req (ifetch_req),
    .ifetch_ack (ifetch_ack),
    .instr_in   (instr_in),
    .in_valid   (in_valid),
    .in_ack     (in_ack),
    .alu_en     (alu_en),
    .sft_en     (sft_en),
    .immd_en    (immd_en),
    .in_en      (in_en),
    .out_en     (out_en),
    .op3        (op3),
    .immd       (immd),
    .AR_idx     (AR_idx),
    .BR_idx     (BR_idx),
    .wr_idx     (wr_idx),
    .rdAR_en    (rdAR_en),
    .rdBR_en    (rdBR_en),
    .wr_en      (wr_en),
    .halted     (halted)
  );

  typedef struct packed {
    logic       alu, sft, li, inn, out, hlt, wr, rda, rdb;
    logic [2:0] bidx;
  } effect_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic        m_fetching;
  logic        m_halted;
  int          m_stage;
  int          fetch_wait;
  int          in_wait;
  logic        directed;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Instruction semantics straight from the ISA table.
  function automatic effect_t effect_of(input logic [15:0] ir);
    effect_t e;
    int      fn;
    e  = '0;
    fn = int'(ir[7:4]);
    if (ir[15:14] == 2'b11) begin
      if (fn <= 6) begin
        e.alu = 1; e.rda = 1; e.rdb = 1; e.bidx = ir[13:11]; e.wr = (fn != 5);
      end else if (fn >= 8 && fn <= 11) begin
        e.sft = 1; e.rdb = 1; e.bidx = ir[10:8]; e.wr = 1;
      end else if (fn == 12) begin
        e.inn = 1; e.wr = 1;
      end else if (fn == 13) begin
        e.out = 1; e.rdb = 1; e.bidx = ir[13:11];
      end else if (fn == 15) begin
        e.hlt = 1;
      end
    end else if (ir[15:14] == 2'b10 && ir[13:11] == 3'b000) begin
      e.li = 1; e.wr = 1;
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    if (r[0]) r[15:14] = 2'b11;
    if (r[15:14] == 2'b11 && r[7:4] == 4'hF) r[7:4] = 4'hE;
    return r;
  endfunction

  function automatic int pick_fetch_wait(input logic [15:0] a);
    if (a == 16'h0010) return 4;
    if (directed && a <= 16'd6) return 0;
    return int'($urandom_range(0, 2));
  endfunction

  function automatic int pick_in_wait(input logic [15:0] a);
    if (directed && a == 16'd6) return 5;
    if (!directed && a == 16'd40) return 10;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, "_pc"}, pc, 16'h0000);
    check_val({tag, "_req"}, ifetch_req, 0);
    check_val({tag, "_halted"}, halted, 0);
    check_val({tag, "_wr_en"}, wr_en, 0);
    check_val({tag, "_in_ack"}, in_ack, 0);
    check_val({tag, "_enables"}, {alu_en, sft_en, immd_en, in_en, out_en, rdAR_en, rdBR_en}, 0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      reset = 1'b1; ifetch_ack = 1'($urandom); in_valid = 1'($urandom);
      #1;
      check_idle("reset");
    end
    @(negedge clk);
    cyc++;
    reset = 1'b0; ifetch_ack = 1'($urandom); in_valid = 1'($urandom);
    #1;
    check_idle("release");
    m_pc = 16'h0000; m_ir = 16'h0000; m_fetching = 1'b1; m_halted = 1'b0; m_stage = 0;
    fetch_wait = pick_fetch_wait(16'h0000);
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic rst);
    effect_t e;
    logic    ack_v, iv, ex, rp, in_wr, wr_exp;
    @(negedge clk);
    cyc++;
    e     = effect_of(m_ir);
    ack_v = 1'($urandom);
    iv    = 1'($urandom);
    if (m_fetching) begin
      ack_v = (fetch_wait == 0);
      if (fetch_wait > 0) fetch_wait--;
    end else if (m_stage == 2 && e.inn) begin
      iv = (in_wait == 0);
      if (in_wait > 0) in_wait--;
    end
    if (rst) iv = 1'b1;
    reset = rst; ifetch_ack = ack_v; in_valid = iv;
    #1;
    check_val("pc", pc, m_pc);
    check_val("ifetch_req", ifetch_req, m_fetching);
    check_val("halted", halted, m_halted);
    ex     = (m_stage == 2);
    rp     = (m_stage == 1 || m_stage == 2);
    in_wr  = ex && e.inn && iv && !rst;
    wr_exp = (ex && e.wr && !e.inn && !rst) || in_wr;
    check_val("wr_en", wr_en, wr_exp);
    check_val("in_ack", in_ack, in_wr);
    if (!rst) begin
      check_val("in_en", in_en, in_wr);
      check_val("alu_en", alu_en, ex && e.alu);
      check_val("sft_en", sft_en, ex && e.sft);
      check_val("immd_en", immd_en, ex && e.li);
      check_val("out_en", out_en, ex && e.out);
      check_val("rdAR_en", rdAR_en, rp && e.rda);
      check_val("rdBR_en", rdBR_en, rp && e.rdb);
      if (rp && e.rda) check_val("AR_idx", AR_idx, m_ir[10:8]);
      if (rp && e.rdb) check_val("BR_idx", BR_idx, e.bidx);
      if (rp) begin
        check_val("op3", op3, (m_ir[15:14] == 2'b11) ? m_ir[7:4] : 4'h0);
        check_val("immd", immd, m_ir[7:0]);
      end
      if (wr_exp) check_val("wr_idx", wr_idx, m_ir[10:8]);
    end
    if (!rst) begin
      if (m_fetching && ack_v) begin
        m_ir       = mem[m_pc[7:0]];
        m_fetching = 1'b0;
        m_stage    = 1;
        in_wait    = pick_in_wait(m_pc);
      end else if (m_stage == 1) begin
        m_stage = 2;
      end else if (m_stage == 2) begin
        if (e.hlt) begin
          m_halted = 1'b1;
          m_stage  = 0;
        end else if (!(e.inn && !iv)) begin
          m_pc       = m_pc + 16'd1;
          m_stage    = 0;
          m_fetching = 1'b1;
          fetch_wait = pick_fetch_wait(m_pc);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; ifetch_ack = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = rand_instr();
    mem[0] = 16'h8105;
    mem[1] = 16'h8203;
    mem[2] = 16'hD100;
    mem[3] = 16'hD150;
    mem[4] = 16'hC8D0;
    mem[5] = 16'hC3B4;
    mem[6] = 16'hC4C0;
    mem[16] = 16'hC0F0;
    directed = 1'b1;
    do_reset(3);
    while (!m_halted && cyc < 5000) step(1'b0);
    check_val("halt_reached", m_halted, 1);
    repeat (6) step(1'b0);
    step(1'b1);

    for (int i = 0; i < 256; i++) mem[i] = rand_instr();
    mem[40] = 16'hC5C0;
    directed = 1'b0;
    do_reset(2);
    while (!(m_stage == 2 && m_pc == 16'd40 && in_wait <= 7) && cyc < 10000) step(1'b0);
    check_val("in_stall_reached", m_pc, 16'd40);
    step(1'b1);
    do_reset(1);
    repeat (60) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_ctrl.md
# simple_ctrl

Multi-cycle control sequencer for the SIMPLE 16-bit processor. It fetches instructions over a request/acknowledge port, decodes them, and drives every control input of the datapath: register-file read/write indices and enables, ALU/shifter opcode, immediate, and the one-hot result-bus drivers. Together with the datapath it forms the complete core, and it owns the program counter and the halt state.

## Interface
- No parameters. Instruction width is fixed at 16, PC width at 16, register index width at 3.
- clk  in  1  single system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- pc  out  16  fetch address; reset 16'h0000
- ifetch_req  out  1  fetch request; high throughout FETCH
- ifetch_ack  in  1  instruction valid on instr_in; sampled only in FETCH
- instr_in  in  16  fetched instruction word
- in_valid  in  1  external input data available on the datapath data_in; sampled only during IN execute
- in_ack  out  1  one-cycle pulse on the cycle the IN result is written
- alu_en, sft_en, immd_en, in_en, out_en  out  1 each  datapath bus/output enables
- op3  out  4  ALU/shifter operation
- immd  out  8  immediate / shift amount
- AR_idx, BR_idx, wr_idx  out  3 each  register indices
- rdAR_en, rdBR_en, wr_en  out  1 each  register-file read and write enables
- halted  out  1  high in HALT

## Operation
- IR (16b) is latched from instr_in on the FETCH cycle where ifetch_ack=1.
- Field names: cls=IR[15:14], Rs=IR[13:11], Rd=IR[10:8], f=IR[7:4]. op3=f when cls=2'b11, else 4'h0. immd=IR[7:0] always.
- States: FETCH -> DECODE (on ack) -> EXEC -> FETCH with PC+1 (16-bit wrap, FFFF->0000). HLT: EXEC -> HALT. HALT is left only by reset.
- cls=11, f=0..6 (ADD,SUB,AND,OR,XOR,CMP,MOV): AR_idx=Rd, BR_idx=Rs, rdAR_en=rdBR_en=1. In EXEC: alu_en=1, wr_idx=Rd, and wr_en=1 except for CMP (f=5), which has wr_en=0.
- cls=11, f=8..11 (SLL,SLR,SRL,SRA): BR_idx=Rd, rdBR_en=1. In EXEC: sft_en=1, wr_en=1, wr_idx=Rd. The shift amount is immd[3:0].
- cls=11, f=12 (IN): EXEC stalls while in_valid=0. On the in_valid=1 cycle: in_en=1, wr_en=1, wr_idx=Rd, in_ack=1.
- cls=11, f=13 (OUT): BR_idx=Rs, rdBR_en=1. In EXEC: out_en=1 for one cycle. No write.
- cls=11, f=15 (HLT): go to HALT. PC does not advance.
- cls=10 with IR[13:11]=000 (LI): in EXEC, immd_en=1, wr_en=1, wr_idx=Rd. The datapath zero-extends the immediate.
- All other encodings (f=7, f=14, remaining cls values): NOP, meaning EXEC asserts no enables and PC advances.
- Invariant: at most one of alu_en/sft_en/immd_en/in_en is high in any cycle. All five enables and wr_en are 0 outside EXEC.

## Timing
- Reset cycle: state=FETCH, pc=0, IR=0, all enables/req/ack/halted=0. ifetch_req rises on the first cycle after reset deasserts.
- Zero-wait fetch: each instruction takes 3 cycles (FETCH, DECODE, EXEC). Each cycle ifetch_ack stays low adds one cycle.
- Read indices and rdAR_en/rdBR_en are valid from DECODE through the end of EXEC, giving the register file a full cycle before the result is consumed.
- wr_en is high for exactly one cycle per writing instruction; wr_idx/op3/immd are stable in that same cycle.
- The pc update and the return to FETCH happen on the clock edge that ends EXEC. For IN, this is the edge ending the in_valid cycle.
- ifetch_ack outside FETCH and in_valid outside IN-EXEC are ignored.
- Reset asserted in any state, including a stalled IN or HALT, aborts immediately. No wr_en or in_ack is produced in that cycle, and the reset values apply on the next edge.

## Test plan
- Reset, then ack every fetch. Sequence LI R1,0x05; LI R2,0x03; ADD R1,R2 (cls 11, Rs=2, Rd=1, f=0) -> wr_en pulses at cycles 3/6/9, and the final write has alu_en=1, op3=0, AR_idx=1, BR_idx=2, wr_idx=1; pc=3 after the ninth cycle.
- CMP R1,R2, then OUT R1 -> CMP shows alu_en=1 with wr_en=0. OUT shows out_en=1 for one cycle, BR_idx=1, and no wr_en.
- SRA R3 by 4 (f=11, IR[3:0]=4) -> sft_en=1, op3=4'hB, immd[3:0]=4, BR_idx=3, wr_idx=3; only one bus enable is high.
- IN R4 with in_valid held low for 5 cycles -> EXEC holds, with no enables asserted and pc unchanged. When in_valid rises, in_en=wr_en=in_ack=1 for one cycle, then FETCH.
- Hold ifetch_ack low for 4 cycles at pc=0x0010 -> ifetch_req stays high and pc stays 0x0010. HLT then gives halted=1, and further acks are ignored until reset.
- Assert reset during an IN stall and, separately, in HALT -> the next cycle has pc=0, halted=0, and no wr_en; ifetch_req=1 on the cycle after reset deasserts.
